// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helper for the parametrised synchronous FIFO.
// Used by fifo_ram and fifo_sync_param (build option: FIFO_FWFT_EN).
package fifo_pkg;

    localparam int FIFO_DATA_W_DEF = 10;
    localparam int FIFO_DEPTH_DEF  = 16;

    function automatic int fifo_addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read address.
// Contents are deliberately not reset so the array can map onto distributed RAM.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter  int DATA_W = FIFO_DATA_W_DEF,
    parameter  int DEPTH  = FIFO_DEPTH_DEF,
    localparam int ADDR_W = fifo_addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with fill level, almost thresholds and sticky errors.
// Define FIFO_FWFT_EN for first-word fall-through; default is a registered read port.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter  int DATA_W = FIFO_DATA_W_DEF,
    parameter  int DEPTH  = FIFO_DEPTH_DEF,
    localparam int ADDR_W = fifo_addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic [ADDR_W:0]   fifo_count,
    input  logic [ADDR_W:0]   af_thresh,
    input  logic [ADDR_W:0]   ae_thresh,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              fifo_almost_full,
    output logic              fifo_almost_empty,
    output logic              fifo_overflow,
    output logic              fifo_underflow,
    input  logic              clr_err
);

    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W:0]   r_wptr;
    logic [ADDR_W:0]   r_rptr;
    logic [ADDR_W:0]   w_count;
    logic              w_we;
    logic              w_re;
    logic [DATA_W-1:0] w_rdata;
    logic              r_overflow;
    logic              r_underflow;

    // Extra pointer bit distinguishes full from empty; count is their modular difference.
    assign w_count    = r_wptr - r_rptr;
    assign fifo_count = w_count;
    assign fifo_full  = (w_count == CNT_FULL);
    assign fifo_empty = (w_count == '0);

    assign fifo_almost_full  = (w_count >= af_thresh);
    assign fifo_almost_empty = (w_count <= ae_thresh);

    assign w_we = wr & ~fifo_full;
    assign w_re = rd & ~fifo_empty;

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wptr[ADDR_W-1:0]),
        .i_wdata (data_in),
        .i_raddr (r_rptr[ADDR_W-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_we) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_re) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
        end
    end

    // A new error in the same cycle as clr_err must not be lost, so set has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr && fifo_full) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (rd && fifo_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign fifo_overflow  = r_overflow;
    assign fifo_underflow = r_underflow;

`ifdef FIFO_FWFT_EN
    assign data_out = w_rdata;
    assign rd_valid = ~fifo_empty;
`else
    logic [DATA_W-1:0] r_data_out;
    logic              r_rd_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_re;
            if (w_re) begin
                r_data_out <= w_rdata;
            end
        end
    end

    assign data_out = r_data_out;
    assign rd_valid = r_rd_valid;
`endif

endmodule
